// File: rtl/arb_2req_if.sv
// arb_2req_if: request/grant handshake between two masters and the arbiter
interface arb_2req_if;
  logic [1:0] request;
  logic [1:0] grant;
  modport master(output request, input grant);
  modport slave(input request, output grant);
endinterface

// File: rtl/arb_2req.sv
// arb_2req: two-requester round-robin arbiter with MAX_HOLD forced rotation under contention.
// ARB_GRANT_GAP_EN inserts one idle grant cycle on every G0<->G1 switch.
module arb_2req #(
  parameter int MAX_HOLD = 4
) (
  input logic clk,
  input logic rst,
  arb_2req_if.slave bus
);
  localparam int HW = $clog2(MAX_HOLD + 1);
`ifdef ARB_GRANT_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  state_t state, nxt, sw;
  logic last, cur, own, oth, expired;
  logic [HW-1:0] hold_cnt;
  always_comb begin
    cur = state == G1;
    own = bus.request[cur];
    oth = bus.request[!cur];
    expired = hold_cnt == HW'(MAX_HOLD - 1);
    sw = cur ? G0 : G1;
    nxt = state;
    if (state == IDLE)
      nxt = bus.request == 2'b00 ? IDLE :
            bus.request == 2'b11 ? (last ? G0 : G1) :
            bus.request[1] ? G1 : G0;
    else if (own && !(oth && expired))
      nxt = state;
    else
      nxt = oth ? (GAP ? IDLE : sw) : IDLE;
  end
  // hold_cnt restarts on any entry into a grant state, so a gap cycle is never counted
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
      hold_cnt <= '0;
      bus.grant <= 2'b00;
    end else begin
      state <= nxt;
      bus.grant <= {nxt == G1, nxt == G0};
      if (nxt != IDLE && nxt != state) begin
        last <= nxt == G1;
        hold_cnt <= '0;
      end else if (state != IDLE && hold_cnt != HW'(MAX_HOLD))
        hold_cnt <= hold_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_arb_2req.sv
// tb_arb_2req: directed stimulus with a per-cycle ownership model and literal spot checks
module tb_arb_2req;
  localparam int MH = 4;
`ifdef ARB_GRANT_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int compared = 0;
  int mismatched = 0;
  arb_2req_if bif();
  arb_2req #(.MAX_HOLD(MH)) dut (.clk(clk), .rst(rst), .bus(bif.slave));
  always #5 clk = ~clk;
  logic has = 1'b0;
  logic owner = 1'b0;
  logic lastg = 1'b1;
  int run = 0;
  logic [1:0] r;
  logic [1:0] exp_g;
  assign exp_g = !has ? 2'b00 : owner ? 2'b10 : 2'b01;
  always @(posedge clk) begin
    r = bif.request;
    if (rst) begin
      has = 1'b0;
      run = 0;
      lastg = 1'b1;
    end else if (has && r[owner] && !(r[!owner] && run >= MH))
      run = run + 1;
    else if (has && r[!owner]) begin
      if (GAP) has = 1'b0;
      else begin
        owner = !owner;
        lastg = owner;
        run = 1;
      end
    end else if (has)
      has = 1'b0;
    else if (r != 2'b00) begin
      has = 1'b1;
      owner = r == 2'b11 ? !lastg : r[1];
      lastg = owner;
      run = 1;
    end
  end
  always @(negedge clk) begin
    compared++;
    if (bif.grant !== exp_g || bif.grant == 2'b11) begin
      mismatched++;
      $display("FAIL model t=%0t: grant=%b expected=%b", $time, bif.grant, exp_g);
    end
  end
  task automatic drive(input logic [1:0] v);
    bif.request = v;
    @(posedge clk);
    #1;
  endtask
  task automatic lit(input string name, input logic [1:0] e);
    compared++;
    if (bif.grant !== e) begin
      mismatched++;
      $display("FAIL %s t=%0t: grant=%b expected=%b", name, $time, bif.grant, e);
    end
  endtask
  function automatic logic [1:0] rot(input int k);
    int m;
    if (!GAP) return ((k / MH) % 2) ? 2'b10 : 2'b01;
    m = k % (2 * MH + 2);
    return m < MH ? 2'b01 : m == MH ? 2'b00 : m < 2 * MH + 1 ? 2'b10 : 2'b00;
  endfunction
  initial begin
    rst = 1'b1;
    bif.request = 2'b00;
    drive(2'b11); lit("reset", 2'b00);
    rst = 1'b0;
    drive(2'b01); lit("first_grant", 2'b01);
    drive(2'b01); lit("grant_stable", 2'b01);
    drive(2'b00); lit("release", 2'b00);
    rst = 1'b1;
    drive(2'b11); lit("rst_ignores_req", 2'b00);
    rst = 1'b0;
    drive(2'b11); lit("tie_to_r0", 2'b01);
    drive(2'b11); lit("tie_hold", 2'b01);
    drive(2'b10);
    if (GAP) begin
      lit("handoff_gap", 2'b00);
      drive(2'b10);
    end
    lit("handoff", 2'b10);
    drive(2'b00); lit("drop_all", 2'b00);
    rst = 1'b1;
    drive(2'b00);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      drive(2'b11);
      lit("rotate", rot(k));
    end
    for (int k = 0; k < 20; k++) begin
      drive(2'b10);
      lit("lone_hold", 2'b10);
    end
    drive(2'b00); lit("idle_again", 2'b00);
    drive(2'b10); lit("g1_again", 2'b10);
    rst = 1'b1;
    drive(2'b11); lit("rst_mid_grant", 2'b00);
    rst = 1'b0;
    drive(2'b11); lit("after_rst_r0", 2'b01);
    drive(2'b00);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
